// File: rtl/arlet6502_pkg.sv
// Shared types and constants for the arlet6502 memory bridge.
package arlet6502_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } bridge_state_e;

  localparam logic [7:0] ERR_DATA_DEFAULT = 8'hFF;

endpackage : arlet6502_pkg

// File: rtl/arlet6502_membridge_bus_timeout.sv
// Watchdog for an outstanding access: counts unacknowledged cycles,
// flags the forced-completion cycle and keeps a sticky error bit.
module bus_timeout #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic busy_i,
  input  logic ack_i,
  input  logic clear_i,
  input  logic err_clr_i,
  output logic tmo_c,
  output logic bus_err_o
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Forced completion fires on the last allowed cycle unless memory acks.
  assign tmo_c     = busy_i && !ack_i && (cnt_q == CNT_LAST);
  assign bus_err_o = err_q;

  // Next counter and sticky-error values; a new timeout beats a clear.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (busy_i && !ack_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (tmo_c) begin
      err_d = 1'b1;
    end else if (err_clr_i) begin
      err_d = 1'b0;
    end
  end

  // Counter and error flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

endmodule : bus_timeout

// File: rtl/arlet6502_membridge.sv
// Bridges the 6502 core's single-cycle bus to a req/ack memory port,
// stalling the core through RDY while an access is outstanding.
module arlet6502_membridge
  import arlet6502_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [7:0]  ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_do,
  input  logic        cpu_we,
  output logic [7:0]  cpu_di,
  output logic        cpu_rdy,
  input  logic        hold,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        bus_err,
  input  logic        err_clr
);

  bridge_state_e state_q;
  logic [15:0]   addr_q;
  logic [7:0]    wdata_q;
  logic          we_q;
  logic [7:0]    rdata_q, rdata_d;
  logic          busy;
  logic          tmo;
  logic          done;

  assign busy = (state_q == ST_BUSY);
  assign done = busy && (mem_ack || tmo);

  // Core handshake: ready when idle or when the outstanding access ends.
  assign cpu_rdy = !hold && (!busy || done);

  // Live read data bypasses the holding register so zero-wait reads work.
  always_comb begin
    cpu_di = rdata_q;
    if (busy && mem_ack && !we_q) begin
      cpu_di = mem_rdata;
    end else if (tmo && !we_q) begin
      cpu_di = ERR_DATA;
    end
  end

  // Read data is latched only when a read completes.
  always_comb begin
    rdata_d = rdata_q;
    if (done && !we_q) begin
      rdata_d = mem_ack ? mem_rdata : ERR_DATA;
    end
  end

  // Bridge FSM with capture registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
      if (cpu_rdy) begin
        state_q <= ST_BUSY;
        addr_q  <= cpu_a;
        wdata_q <= cpu_do;
        we_q    <= cpu_we;
      end else if (done) begin
        state_q <= ST_IDLE;
      end
    end
  end

  assign mem_req   = busy;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // Timeout watchdog; restarts on every capture or completion.
  bus_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_bus_timeout (
    .clk       (clk),
    .reset     (reset),
    .busy_i    (busy),
    .ack_i     (mem_ack),
    .clear_i   (cpu_rdy || done),
    .err_clr_i (err_clr),
    .tmo_c     (tmo),
    .bus_err_o (bus_err)
  );

endmodule : arlet6502_membridge

// File: doc/arlet6502_membridge.md
# arlet6502_membridge

Bus bridge sitting directly downstream of the `arlet6502` CPU core. It converts the core's single-cycle synchronous-memory bus (address, data, WE, RDY, DI) into a request/acknowledge memory port with variable latency. It stalls the core through RDY while an access is outstanding, holds read data stable for the core's DI mux, and force-completes hung accesses with a timeout and a sticky error flag.

## Interface
Parameters:
- `TIMEOUT`, 64: number of consecutive unacknowledged `mem_req` cycles before forced completion; legal range 2..256.
- `ERR_DATA`, 8'hFF: read data returned on a timed-out read.

Ports:
- `clk` in 1: CPU clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `cpu_a` in 16: CPU address (core `A`).
- `cpu_do` in 8: CPU write data (core `DO`).
- `cpu_we` in 1: CPU write enable (core `WE`).
- `cpu_di` out 8: read data to the core (`DI`).
- `cpu_rdy` out 1: ready to the core (`RDY`); 0 stalls the core.
- `hold` in 1: external stall request (DMA/debug).
- `mem_req` out 1: access outstanding.
- `mem_we` out 1: outstanding access is a write.
- `mem_addr` out 16: access address.
- `mem_wdata` out 8: write data.
- `mem_ack` in 1: access complete this cycle; ignored when `mem_req`=0.
- `mem_rdata` in 8: read data, valid with `mem_ack` on reads.
- `bus_err` out 1: sticky timeout flag.
- `err_clr` in 1: clears `bus_err`.

## Operation
- States: IDLE (no access outstanding, `mem_req`=0) and BUSY (`mem_req`=1).
- Capture: at every rising edge where `cpu_rdy`=1, register `cpu_a`/`cpu_we`/`cpu_do` into `mem_addr`/`mem_we`/`mem_wdata`, clear the timeout counter, and go to BUSY.
- done = BUSY && (`mem_ack` || tmo). tmo = BUSY && !`mem_ack` && cnt==TIMEOUT-1.
- `cpu_rdy` = !`hold` && (IDLE || done). This is combinational from `hold` and `mem_ack`.
- `cpu_di` = `mem_rdata` if (BUSY && `mem_ack` && !`mem_we`). Otherwise ERR_DATA if (tmo && !`mem_we`). Otherwise `rdata_q`.
- `rdata_q` updates at the done edge of reads only: `mem_rdata`, or ERR_DATA on tmo. Writes leave it unchanged.
- Done edge with `cpu_rdy`=1: new capture, stay BUSY (back-to-back, zero-wait when memory acks in its first cycle).
- Done edge with `hold`=1: go IDLE. The next capture occurs at the first edge with `hold`=0.
- Counter: increments each BUSY cycle without ack. Its width is enough for TIMEOUT-1.
- `bus_err`: set at the tmo edge, cleared by `err_clr`. Simultaneous set and clear: set wins.
- `mem_ack` and tmo in the same cycle: ack wins, no error.

## Timing
- Reset values: `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `rdata_q`=0 (`cpu_di`=0), `bus_err`=0, counter=0, state IDLE.
- While `reset`=1: `cpu_rdy`=!`hold`, and no capture happens. The first capture occurs at the first edge with `reset`=0.
- Reset asserted mid-access: the access is abandoned immediately and `mem_req` drops asynchronously.
- Zero-wait access: address captured at edge k, `mem_req` high in cycle k+1. If `mem_ack`=1 in k+1, `cpu_rdy`=1 and `cpu_di`=`mem_rdata` in that same cycle.
- N-cycle ack: `cpu_rdy`=0 for N-1 cycles, and `mem_addr` stays stable throughout.
- Timeout: `mem_req` stays high for exactly TIMEOUT cycles. `cpu_rdy`=1 in the last of them.
- `mem_*` outputs are registered. The only combinational paths are `mem_ack`/`mem_rdata`/`hold` → `cpu_rdy`/`cpu_di`.

## Structure
- Shared package `arlet6502_pkg`: state encoding (IDLE/BUSY) and the default ERR_DATA constant.
- One natural sub-module: `bus_timeout`, holding the counter, tmo compare, and sticky `bus_err`/`err_clr` logic, parameterised by TIMEOUT.
- The top-level bridge contains the capture registers, `rdata_q`, the FSM, and the `cpu_rdy`/`cpu_di` muxes.

## Test plan
- Zero-wait read: `cpu_a`=16'h1234, `mem_ack` tied high, `mem_rdata`=8'hA5. Required: `cpu_rdy` never drops, `cpu_di`=8'hA5 the cycle after capture, and `mem_addr`=16'h1234.
- 3-cycle write: `cpu_we`=1, `cpu_do`=8'h3C to 16'h0200, ack on the 3rd `mem_req` cycle. Required: `cpu_rdy`=0 for 2 cycles, `mem_wdata`=8'h3C held, and `rdata_q` unchanged.
- Timeout: TIMEOUT=4, read, never ack. Required: `mem_req` high exactly 4 cycles, `cpu_di`=8'hFF, `bus_err`=1. Then `err_clr` pulse → `bus_err`=0.
- Hold during completion: `hold`=1 while ack arrives with 8'h5A. Required: state IDLE, `cpu_rdy`=0. Release `hold` → `cpu_rdy`=1, `cpu_di`=8'h5A, new capture on that edge.
- Reset mid-access: assert `reset` in the 2nd wait cycle. Required: `mem_req`=0 immediately, all outputs at reset values, first capture at the first edge after release.
- Ack and tmo coincide (TIMEOUT=2, ack on the 2nd cycle). Required: `cpu_di`=`mem_rdata` and `bus_err` stays 0.
